// File: rtl/pattern_seq_ctrl.sv
// Pattern sequencer controller: writable table, stepped over len+1 entries
// for rpt+1 passes, each word offered on a valid/ready handshake.
// Ports: clk, rst (async, active high)
//        cfg_we/cfg_addr/cfg_data : table write, honoured in IDLE only
//        len/rpt/start/abort      : sequence control, len/rpt sampled at start
//        q/q_valid/q_ready/idx    : output stream and index of word on q
//        busy (RUN or DONE), done (one-cycle completion pulse)
module pattern_seq_ctrl #(
   parameter int DW    = 4,
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int RPT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [DW-1:0]    cfg_data,
   input  logic [AW-1:0]    len,
   input  logic [RPT_W-1:0] rpt,
   input  logic             start,
   input  logic             abort,
   output logic [DW-1:0]    q,
   output logic             q_valid,
   input  logic             q_ready,
   output logic [AW-1:0]    idx,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [DW-1:0]    tbl_q [DEPTH];
   logic [DW-1:0]    word_q, word_d;
   logic             valid_q, valid_d;
   logic [AW-1:0]    idx_q, idx_d, idx_nxt;
   logic [AW-1:0]    len_q, len_d;
   logic [RPT_W-1:0] pass_q, pass_d;
   logic [RPT_W-1:0] rpt_q, rpt_d;
   logic             tbl_we;

   function automatic logic [DW-1:0] tbl_init(input int i);
      case (i)
         1:       return DW'(4'b0001);
         2:       return DW'(4'b0011);
         3:       return DW'(4'b0111);
         4:       return DW'(4'b1001);
         5:       return DW'(4'b1101);
         default: return '0;
      endcase
   endfunction

   // Table is frozen while a sequence is in flight.
   assign tbl_we = cfg_we && (state_q == S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) tbl_q[i] <= tbl_init(i);
      end else if (tbl_we) begin
         tbl_q[cfg_addr] <= cfg_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         word_q  <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
         len_q   <= '0;
         pass_q  <= '0;
         rpt_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         pass_q  <= pass_d;
         rpt_q   <= rpt_d;
      end
   end

   assign idx_nxt = idx_q + AW'(1);

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      valid_d = valid_q;
      idx_d   = idx_q;
      len_d   = len_q;
      pass_d  = pass_q;
      rpt_d   = rpt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               len_d   = len;
               rpt_d   = rpt;
               idx_d   = '0;
               pass_d  = '0;
               word_d  = tbl_q[0];
               valid_d = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               valid_d = 1'b0;
               idx_d   = '0;
               state_d = S_IDLE;
            end else if (valid_q && q_ready) begin
               if (idx_q != len_q) begin
                  idx_d  = idx_nxt;
                  word_d = tbl_q[idx_nxt];
               end else if (pass_q != rpt_q) begin
                  // Wrap to the next pass without a bubble.
                  idx_d  = '0;
                  pass_d = pass_q + RPT_W'(1);
                  word_d = tbl_q[0];
               end else begin
                  valid_d = 1'b0;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            valid_d = 1'b0;
            state_d = S_IDLE;
            if (abort) idx_d = '0;
         end
         default: begin
            valid_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign q       = word_q;
   assign q_valid = valid_q;
   assign idx     = idx_q;
   assign busy    = (state_q != S_IDLE);
   // An abort arriving during DONE cancels the completion pulse.
   assign done    = (state_q == S_DONE) && !abort;

endmodule
